// File: rtl/blob_record_writer.sv
// blob_record_writer: producer side of the blob-record list in shared SRAM.
// Each accepted descriptor becomes a 3-word record at BASE_ADDRESS + 3n.
// At frame end a 3-word all-ones termination record is appended.
// Optional feature macro: BLOB_WRITER_SIZE_FILTER_EN. When it is defined,
// blobs smaller than minimum_blob_size are accepted but not stored.
//
// Handshake: a descriptor transfers on a rising clk edge where blob_valid
// and blob_ready are both 1. blob_ready is a registered "in WAIT_BLOB" flag
// gated by pause, so a transfer can never complete while the arbiter stalls us.
module blob_record_writer #(
  parameter int unsigned BASE_ADDRESS = 200000,
  parameter int unsigned MAX_BLOBS    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        enable_blob_writer,
  input  logic        blob_valid,
  output logic        blob_ready,
  input  logic [15:0] blob_x_min,
  input  logic [15:0] blob_x_max,
  input  logic [15:0] blob_y_min,
  input  logic [15:0] blob_y_max,
  input  logic [31:0] blob_pixel_count,
  input  logic        frame_end,
  input  logic [7:0]  minimum_blob_size,
  output logic        wren,
  output logic [31:0] data_write,
  output logic [17:0] address,
  output logic [15:0] blob_extraction_blob_counter,
  output logic        blob_overflow,
  output logic        blob_writer_done,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_BLOB, S_WR0, S_WR1, S_WR2, S_TERM0, S_TERM1, S_TERM2, S_DONE
  } state_t;

  localparam logic [17:0] BASE_ADDR = 18'(BASE_ADDRESS);
  localparam logic [15:0] MAX_CNT   = 16'(MAX_BLOBS);
  localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic        enable_q;
  logic        ready_q, ready_d;
  logic        wren_q, wren_d;
  logic [31:0] data_q, data_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        fe_pend_q, fe_pend_d;
  logic [31:0] y_q, y_d;
  logic [31:0] pix_q, pix_d;
  logic        accept;
  logic        drop;
  logic        small_blob;

`ifdef BLOB_WRITER_SIZE_FILTER_EN
  assign small_blob = blob_pixel_count < {24'd0, minimum_blob_size};
`else
  assign small_blob = 1'b0;
  logic unused_min_size;
  assign unused_min_size = ^minimum_blob_size;
`endif

  // Next-state, record sequencing and registered write-port values.
  always_comb begin
    state_d   = state_q;
    wren_d    = wren_q;
    data_d    = data_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    fe_pend_d = fe_pend_q;
    y_d       = y_q;
    pix_d     = pix_q;
    accept    = blob_valid && ready_q;
    drop      = 1'b0;

    if (!enable_blob_writer && state_q != S_IDLE && state_q != S_DONE) begin
      // Mid-frame abort: stop writing, no termination record.
      state_d   = S_IDLE;
      wren_d    = 1'b0;
      fe_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wren_d = 1'b0;
          if (enable_blob_writer && !enable_q) begin
            cnt_d     = '0;
            ovf_d     = 1'b0;
            done_d    = 1'b0;
            fe_pend_d = 1'b0;
            addr_d    = BASE_ADDR;
            state_d   = S_WAIT_BLOB;
          end
        end
        S_WAIT_BLOB: begin
          if (accept) begin
            if (small_blob) begin
              drop = 1'b1;
            end else if (cnt_q == MAX_CNT) begin
              drop  = 1'b1;
              ovf_d = 1'b1;
            end else begin
              y_d       = {blob_y_min, blob_y_max};
              pix_d     = blob_pixel_count;
              data_d    = {blob_x_min, blob_x_max};
              wren_d    = 1'b1;
              fe_pend_d = frame_end;
              state_d   = S_WR0;
            end
            if (drop && frame_end) begin
              state_d = S_TERM0;
              wren_d  = 1'b1;
              data_d  = TERM_WORD;
            end
          end else if (frame_end) begin
            state_d = S_TERM0;
            wren_d  = 1'b1;
            data_d  = TERM_WORD;
          end
        end
        S_WR0: begin
          addr_d    = addr_q + 18'd1;
          data_d    = y_q;
          fe_pend_d = fe_pend_q || frame_end;
          state_d   = S_WR1;
        end
        S_WR1: begin
          addr_d    = addr_q + 18'd1;
          data_d    = pix_q;
          fe_pend_d = fe_pend_q || frame_end;
          state_d   = S_WR2;
        end
        S_WR2: begin
          addr_d = addr_q + 18'd1;
          cnt_d  = cnt_q + 16'd1;
          if (fe_pend_q || frame_end) begin
            fe_pend_d = 1'b0;
            wren_d    = 1'b1;
            data_d    = TERM_WORD;
            state_d   = S_TERM0;
          end else begin
            wren_d  = 1'b0;
            state_d = S_WAIT_BLOB;
          end
        end
        S_TERM0: begin
          addr_d  = addr_q + 18'd1;
          state_d = S_TERM1;
        end
        S_TERM1: begin
          addr_d  = addr_q + 18'd1;
          state_d = S_TERM2;
        end
        S_TERM2: begin
          addr_d  = addr_q + 18'd1;
          wren_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          wren_d = 1'b0;
          if (!enable_blob_writer) begin
            done_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          wren_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end

    ready_d = (state_d == S_WAIT_BLOB);
  end

  // State and datapath registers; pause freezes everything so a stalled write reissues unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      ready_q   <= 1'b0;
      wren_q    <= 1'b0;
      data_q    <= '0;
      addr_q    <= BASE_ADDR;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      fe_pend_q <= 1'b0;
      y_q       <= '0;
      pix_q     <= '0;
    end else if (!pause) begin
      state_q   <= state_d;
      enable_q  <= enable_blob_writer;
      ready_q   <= ready_d;
      wren_q    <= wren_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      fe_pend_q <= fe_pend_d;
      y_q       <= y_d;
      pix_q     <= pix_d;
    end
  end

  assign blob_ready                   = ready_q && !pause;
  assign wren                         = wren_q && !pause;
  assign data_write                   = data_q;
  assign address                      = addr_q;
  assign blob_extraction_blob_counter = cnt_q;
  assign blob_overflow                = ovf_q;
  assign blob_writer_done             = done_q;
  assign dbg_state_o                  = state_q;

endmodule

// File: tb/tb_blob_record_writer.sv
// Bench for blob_record_writer: directed frames plus random frames with
// random arbiter stalls, every SRAM write checked against a scoreboard
// built from the record-list rules.
module tb_blob_record_writer;

  localparam int BASE = 200000;
  localparam int MAXB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic        enable_blob_writer;
  logic        blob_valid;
  logic        blob_ready;
  logic [15:0] blob_x_min, blob_x_max, blob_y_min, blob_y_max;
  logic [31:0] blob_pixel_count;
  logic        frame_end;
  logic [7:0]  minimum_blob_size;
  logic        wren;
  logic [31:0] data_write;
  logic [17:0] address;
  logic [15:0] blob_extraction_blob_counter;
  logic        blob_overflow;
  logic        blob_writer_done;
  logic [3:0]  dbg_state_o;

  blob_record_writer #(.BASE_ADDRESS(BASE), .MAX_BLOBS(MAXB)) dut (
    .clk(clk), .reset(reset), .pause(pause),
    .enable_blob_writer(enable_blob_writer),
    .blob_valid(blob_valid), .blob_ready(blob_ready),
    .blob_x_min(blob_x_min), .blob_x_max(blob_x_max),
    .blob_y_min(blob_y_min), .blob_y_max(blob_y_max),
    .blob_pixel_count(blob_pixel_count), .frame_end(frame_end),
    .minimum_blob_size(minimum_blob_size),
    .wren(wren), .data_write(data_write), .address(address),
    .blob_extraction_blob_counter(blob_extraction_blob_counter),
    .blob_overflow(blob_overflow), .blob_writer_done(blob_writer_done),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [49:0] exp_q[$];   // {address, data} in write order
  int          exp_cnt;
  logic        exp_ovf;

  logic [15:0] bx0[8], bx1[8], by0[8], by1[8];
  logic [31:0] bpc[8];

  function automatic bit is_small(input int i);
`ifdef BLOB_WRITER_SIZE_FILTER_EN
    return bpc[i] < 32'(minimum_blob_size);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_word(input int addr, input logic [31:0] d);
    exp_q.push_back({18'(addr), d});
  endtask

  // Record list for a completed frame of nb blobs.
  task automatic model_frame(input int nb);
    int n;
    n = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (is_small(i)) continue;
      if (n == MAXB) begin
        exp_ovf = 1'b1;
      end else begin
        push_word(BASE + 3 * n + 0, {bx0[i], bx1[i]});
        push_word(BASE + 3 * n + 1, {by0[i], by1[i]});
        push_word(BASE + 3 * n + 2, bpc[i]);
        n++;
      end
    end
    for (int k = 0; k < 3; k++) push_word(BASE + 3 * n + k, 32'hFFFF_FFFF);
    exp_cnt = n;
  endtask

  // Write monitor: every observed write must be the next expected one.
  always @(negedge clk) begin
    logic [49:0] e;
    if (!reset) begin
      if (pause) check("wren_in_pause", {63'd0, wren}, 64'd0);
      if (wren) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {63'd0, wren}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {46'd0, address}, {46'd0, e[49:32]});
          check("wr_data", {32'd0, data_write}, {32'd0, e[31:0]});
        end
      end
    end
  end

  // Random arbiter stalls, changed away from both clock edges.
  bit rand_pause_en = 1'b0;
  always @(posedge clk) begin
    #2;
    if (rand_pause_en) pause = ($urandom_range(0, 3) == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    @(negedge clk);
    enable_blob_writer = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!blob_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!blob_ready) check("ready_timeout", {63'd0, blob_ready}, 64'd1);
  endtask

  task automatic send_blob(input int i, input bit fe, input bit hold_wr1);
    @(negedge clk);
    blob_x_min = bx0[i]; blob_x_max = bx1[i];
    blob_y_min = by0[i]; blob_y_max = by1[i];
    blob_pixel_count = bpc[i];
    blob_valid = 1'b1;
    wait_ready();
    frame_end = fe;
    @(posedge clk);
    #1;
    blob_valid = 1'b0;
    frame_end  = 1'b0;
    if (hold_wr1) begin
      @(posedge clk);      // WR0 -> WR1
      #2 pause = 1'b1;
      repeat (5) @(posedge clk);
      #2 pause = 1'b0;
    end
  endtask

  task automatic send_frame_end();
    @(negedge clk);
    wait_ready();
    frame_end = 1'b1;
    @(posedge clk);
    #1 frame_end = 1'b0;
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (!blob_writer_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    rand_pause_en = 1'b0;
    @(negedge clk);
    pause = 1'b0;
    check("done", {63'd0, blob_writer_done}, 64'd1);
    check("counter", {48'd0, blob_extraction_blob_counter}, 64'(exp_cnt));
    check("overflow", {63'd0, blob_overflow}, {63'd0, exp_ovf});
    check("writes_left", 64'(exp_q.size()), 64'd0);
    check("wren_done", {63'd0, wren}, 64'd0);
    enable_blob_writer = 1'b0;
    repeat (2) @(negedge clk);
    check("done_clear", {63'd0, blob_writer_done}, 64'd0);
    check("idle_after_done", {60'd0, dbg_state_o}, 64'd0);
  endtask

  task automatic run_frame(input int nb, input bit fe_last, input bit hold, input bit rp);
    model_frame(nb);
    start_frame();
    rand_pause_en = rp;
    for (int i = 0; i < nb; i++) send_blob(i, fe_last && (i == nb - 1), hold && (i == 0));
    if (!(fe_last && nb > 0)) send_frame_end();
    finish_frame();
  endtask

  task automatic set_blob(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d, input logic [31:0] p);
    bx0[i] = a; bx1[i] = b; by0[i] = c; by1[i] = d; bpc[i] = p;
  endtask

  task automatic randomize_blobs(input int nb);
    for (int i = 0; i < nb; i++)
      set_blob(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom));
  endtask

  // Abort during WR1 of the second blob: first record complete, half of the second written.
  task automatic abort_frame();
    set_blob(0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 32'h0000_0200);
    set_blob(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 32'h0000_0300);
    minimum_blob_size = 8'h00;
    push_word(BASE + 0, 32'h0A0A_0B0B);
    push_word(BASE + 1, 32'h0C0C_0D0D);
    push_word(BASE + 2, 32'h0000_0200);
    push_word(BASE + 3, 32'h1111_2222);
    push_word(BASE + 4, 32'h3333_4444);
    start_frame();
    send_blob(0, 1'b0, 1'b0);
    send_blob(1, 1'b0, 1'b0);
    @(negedge clk);              // in WR0
    @(negedge clk);              // in WR1
    enable_blob_writer = 1'b0;
    @(negedge clk);
    check("abort_idle", {60'd0, dbg_state_o}, 64'd0);
    check("abort_wren", {63'd0, wren}, 64'd0);
    repeat (3) @(negedge clk);
    check("abort_done", {63'd0, blob_writer_done}, 64'd0);
    check("abort_counter", {48'd0, blob_extraction_blob_counter}, 64'd1);
    check("abort_writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; pause = 1'b0; enable_blob_writer = 1'b0; blob_valid = 1'b0;
    blob_x_min = '0; blob_x_max = '0; blob_y_min = '0; blob_y_max = '0;
    blob_pixel_count = '0; frame_end = 1'b0; minimum_blob_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wren", {63'd0, wren}, 64'd0);
    check("rst_data", {32'd0, data_write}, 64'd0);
    check("rst_addr", {46'd0, address}, 64'(BASE));
    check("rst_ready", {63'd0, blob_ready}, 64'd0);
    check("rst_counter", {48'd0, blob_extraction_blob_counter}, 64'd0);
    check("rst_overflow", {63'd0, blob_overflow}, 64'd0);
    check("rst_done", {63'd0, blob_writer_done}, 64'd0);
    check("rst_state", {60'd0, dbg_state_o}, 64'd0);
    reset = 1'b0;

    // Two blobs then frame_end.
    set_blob(0, 16'h1020, 16'h1001, 16'h1010, 16'h1010, 32'h0000_3030);
    set_blob(1, 16'h2000, 16'h2005, 16'h0100, 16'h0180, 32'h0000_4444);
    run_frame(2, 1'b0, 1'b0, 1'b0);
    // Empty frame.
    run_frame(0, 1'b0, 1'b0, 1'b0);
    // Same two blobs with a 5-cycle stall during WR1 of blob 0.
    run_frame(2, 1'b0, 1'b1, 1'b0);
    // One more blob than fits.
    randomize_blobs(4);
    for (int i = 0; i < 4; i++) bpc[i] = 32'h0001_0000 + 32'(i);
    run_frame(4, 1'b0, 1'b0, 1'b0);
    // Blob and frame_end in the same cycle.
    set_blob(0, 16'hABCD, 16'h1234, 16'h5678, 16'h9ABC, 32'h0000_0777);
    run_frame(1, 1'b1, 1'b0, 1'b0);
    // Small/large blob pair around the size threshold.
    minimum_blob_size = 8'h40;
    set_blob(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 32'h0000_0030);
    set_blob(1, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 32'h0000_0050);
    run_frame(2, 1'b0, 1'b0, 1'b0);
    // Enable dropped mid-record.
    abort_frame();

    // Random frames with random stalls.
    for (int f = 0; f < 30; f++) begin
      int nb;
      nb = $urandom_range(0, 5);
      minimum_blob_size = 8'($urandom);
      randomize_blobs(nb);
      run_frame(nb, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
